keynsham_timer: RTL and testbench

Memory-mapped countdown timer peripheral on the keynsham SoC data bus, decoded at 0x80002000–0x80002fff alongside the UART and SDRAM controller. Provides `NUM_TIMERS` independent 32-bit down-counters with reload, one-shot/periodic modes and per-timer level interrupts. It is a bus slave: it consumes CPU data-bus accesses and returns data, ack or error into the SoC read-data and ack/error ORs.

---
 rtl/keynsham_timer_if.sv | 23 ++
 rtl/keynsham_timer.sv | 124 ++++++++++++
 tb/tb_keynsham_timer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/keynsham_timer_if.sv
// CPU data-bus slave port of the keynsham timer peripheral.
// A request is a single-cycle bus_access && bus_cs strobe with no backpressure; each one is answered by exactly one bus_ack or bus_error pulse in the following cycle, in order.
interface keynsham_timer_if;
    logic        bus_access;
    logic        bus_cs;
    logic [31:0] bus_addr;
    logic [31:0] bus_wr_val;
    logic        bus_wr_en;
    logic [3:0]  bus_bytesel;
    logic        bus_ack;
    logic        bus_error;
    logic [31:0] bus_data;

    modport master (
        output bus_access, bus_cs, bus_addr, bus_wr_val, bus_wr_en, bus_bytesel,
        input  bus_ack, bus_error, bus_data
    );

    modport slave (
        input  bus_access, bus_cs, bus_addr, bus_wr_val, bus_wr_en, bus_bytesel,
        output bus_ack, bus_error, bus_data
    );
endinterface

// File: rtl/keynsham_timer.sv
// Memory-mapped bank of NUM_TIMERS 32-bit down-counters with reload, one-shot/periodic
// modes and level interrupts; each timer occupies 16 bytes (COUNT, RELOAD, CONTROL, STATUS).
module keynsham_timer #(
    parameter int NUM_TIMERS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    keynsham_timer_if.slave       bus,
    output logic [NUM_TIMERS-1:0] irq
);
    localparam logic [1:0] REG_COUNT   = 2'd0;
    localparam logic [1:0] REG_RELOAD  = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;

    logic [31:0]           count_q  [NUM_TIMERS];
    logic [31:0]           reload_q [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] en_q;
    logic [NUM_TIMERS-1:0] periodic_q;
    logic [NUM_TIMERS-1:0] irq_en_q;
    logic [NUM_TIMERS-1:0] pending_q;
    logic                  ack_q;
    logic                  error_q;
    logic [31:0]           data_q;

    logic                  accept;
    logic [7:0]            idx;
    logic [1:0]            reg_sel;
    logic                  idx_ok;
    logic [31:0]           byte_mask;
    logic [31:0]           sel_reload;
    logic [31:0]           reload_merged;
    logic [31:0]           rd_data;
    logic [NUM_TIMERS-1:0] wr_reload;
    logic [NUM_TIMERS-1:0] wr_control;
    logic [NUM_TIMERS-1:0] wr_status;
    logic                  unused_addr;

    assign accept      = bus.bus_access & bus.bus_cs;
    assign idx         = bus.bus_addr[11:4];
    assign reg_sel     = bus.bus_addr[3:2];
    assign idx_ok      = (idx < 8'(NUM_TIMERS));
    assign unused_addr = ^{bus.bus_addr[31:12], bus.bus_addr[1:0]};

    assign byte_mask = {{8{bus.bus_bytesel[3]}}, {8{bus.bus_bytesel[2]}},
                        {8{bus.bus_bytesel[1]}}, {8{bus.bus_bytesel[0]}}};
    assign reload_merged = (sel_reload & ~byte_mask) | (bus.bus_wr_val & byte_mask);

    // Address decode: read mux plus one-hot write strobes for the addressed timer.
    always_comb begin
        sel_reload = '0;
        rd_data    = '0;
        wr_reload  = '0;
        wr_control = '0;
        wr_status  = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (accept && idx == 8'(i)) begin
                sel_reload = reload_q[i];
                case (reg_sel)
                    REG_COUNT:   rd_data = count_q[i];
                    REG_RELOAD:  rd_data = reload_q[i];
                    REG_CONTROL: rd_data = {29'd0, irq_en_q[i], periodic_q[i], en_q[i]};
                    default:     rd_data = {31'd0, pending_q[i]};
                endcase
                if (bus.bus_wr_en) begin
                    wr_reload[i]  = (reg_sel == REG_RELOAD);
                    wr_control[i] = (reg_sel == REG_CONTROL) && bus.bus_bytesel[0];
                    wr_status[i]  = (reg_sel == 2'd3) && (bus.bus_bytesel != 4'd0);
                end
            end
        end
    end

    // Assignment order sets priority: later writes in this block win on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                count_q[i]  <= '0;
                reload_q[i] <= '0;
            end
            en_q       <= '0;
            periodic_q <= '0;
            irq_en_q   <= '0;
            pending_q  <= '0;
            ack_q      <= 1'b0;
            error_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            ack_q   <= accept & idx_ok;
            error_q <= accept & ~idx_ok;
            data_q  <= (accept && idx_ok && !bus.bus_wr_en) ? rd_data : '0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (wr_status[i]) begin
                    pending_q[i] <= 1'b0;
                end
                if (en_q[i]) begin
                    if (count_q[i] != 32'd0) begin
                        count_q[i] <= count_q[i] - 32'd1;
                    end else begin
                        pending_q[i] <= 1'b1;
                        if (periodic_q[i]) begin
                            count_q[i] <= reload_q[i];
                        end else begin
                            en_q[i] <= 1'b0;
                        end
                    end
                end
                if (wr_reload[i]) begin
                    reload_q[i] <= reload_merged;
                    count_q[i]  <= reload_merged;
                end
                if (wr_control[i]) begin
                    en_q[i]       <= bus.bus_wr_val[0];
                    periodic_q[i] <= bus.bus_wr_val[1];
                    irq_en_q[i]   <= bus.bus_wr_val[2];
                end
            end
        end
    end

    assign bus.bus_ack   = ack_q;
    assign bus.bus_error = error_q;
    assign bus.bus_data  = data_q;
    assign irq           = pending_q & irq_en_q;
endmodule

// File: tb/tb_keynsham_timer.sv
// Bench for keynsham_timer: directed scenarios plus random bus traffic, with responses and
// interrupts checked against a cycle-level reference model of the timer bank.
module tb_keynsham_timer;
    localparam int NT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NT-1:0] irq;

    keynsham_timer_if bus ();

    keynsham_timer #(.NUM_TIMERS(NT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0]   m_count  [NT];
    logic [31:0]   m_reload [NT];
    logic [NT-1:0] m_en, m_per, m_ien, m_pend;

    // {is_error, check_data, data}
    logic [33:0] exp_q[$];
    logic [33:0] mon_e;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_count[i]  = '0;
            m_reload[i] = '0;
        end
        m_en = '0; m_per = '0; m_ien = '0; m_pend = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int t;
        t = int'(addr[11:4]);
        case (addr[3:2])
            2'd0:    return m_count[t];
            2'd1:    return m_reload[t];
            2'd2:    return {29'd0, m_ien[t], m_per[t], m_en[t]};
            default: return {31'd0, m_pend[t]};
        endcase
    endfunction

    // Advance the model across one clock edge with the given bus inputs.
    task automatic model_step(input logic acc, input logic cs, input logic [31:0] addr,
                              input logic [31:0] wval, input logic wen, input logic [3:0] bsel);
        logic [NT-1:0] expired;
        logic [31:0]   mask;
        int            t;
        expired = '0;
        for (int i = 0; i < NT; i++) begin
            if (m_en[i]) begin
                if (m_count[i] != 0) begin
                    m_count[i] = m_count[i] - 1;
                end else begin
                    expired[i] = 1'b1;
                    m_pend[i]  = 1'b1;
                    if (m_per[i]) m_count[i] = m_reload[i];
                    else          m_en[i]    = 1'b0;
                end
            end
        end
        if (acc && cs && addr[11:4] < NT && wen) begin
            t    = int'(addr[11:4]);
            mask = {{8{bsel[3]}}, {8{bsel[2]}}, {8{bsel[1]}}, {8{bsel[0]}}};
            case (addr[3:2])
                2'd1: begin
                    m_reload[t] = (m_reload[t] & ~mask) | (wval & mask);
                    m_count[t]  = m_reload[t];
                end
                2'd2: if (bsel[0]) begin
                    m_en[t]  = wval[0];
                    m_per[t] = wval[1];
                    m_ien[t] = wval[2];
                end
                2'd3: if (bsel != 4'd0 && !expired[t]) m_pend[t] = 1'b0;
                default: ;
            endcase
        end
    endtask

    // ---------------- driver ----------------
    function automatic logic [31:0] addr_of(input int t, input int r);
        return 32'h8000_2000 + 32'(t * 16) + 32'(r * 4);
    endfunction

    task automatic drive_idle();
        bus.bus_access  = 1'b0;
        bus.bus_cs      = 1'b0;
        bus.bus_addr    = '0;
        bus.bus_wr_val  = '0;
        bus.bus_wr_en   = 1'b0;
        bus.bus_bytesel = '0;
    endtask

    task automatic bus_cycle(input logic acc, input logic cs, input logic [31:0] addr,
                             input logic [31:0] wval, input logic wen, input logic [3:0] bsel);
        @(negedge clk);
        bus.bus_access  = acc;
        bus.bus_cs      = cs;
        bus.bus_addr    = addr;
        bus.bus_wr_val  = wval;
        bus.bus_wr_en   = wen;
        bus.bus_bytesel = bsel;
        if (acc && cs) begin
            if (addr[11:4] >= NT) exp_q.push_back({1'b1, 1'b1, 32'd0});
            else if (wen)         exp_q.push_back({1'b0, 1'b0, 32'd0});
            else                  exp_q.push_back({1'b0, 1'b1, model_read(addr)});
        end
        model_step(acc, cs, addr, wval, wen, bsel);
        @(posedge clk);
        #2;
    endtask

    task automatic rd(input int t, input int r);
        bus_cycle(1'b1, 1'b1, addr_of(t, r), 32'd0, 1'b0, 4'd0);
    endtask

    task automatic wr(input int t, input int r, input logic [31:0] v, input logic [3:0] bsel);
        bus_cycle(1'b1, 1'b1, addr_of(t, r), v, 1'b1, bsel);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("bus_resp_kind", {30'd0, bus.bus_error, bus.bus_ack},
                      mon_e[33] ? 32'd2 : 32'd1);
                if (mon_e[32]) check("bus_resp_data", bus.bus_data, mon_e[31:0]);
            end else begin
                check("bus_idle_resp", {30'd0, bus.bus_error, bus.bus_ack}, 32'd0);
                check("bus_idle_data", bus.bus_data, 32'd0);
            end
            check("irq", 32'(irq), 32'(m_pend & m_ien));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (%0d/%0d checks passed so far)",
                 n_pass, n_checks);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    logic [31:0] a, wv;
    int          t, r;
    int          seq [4] = '{3, 2, 1, 0};

    initial begin
        drive_idle();
        model_reset();
        #1;
        check("rst_ack", 32'(bus.bus_ack), 32'd0);
        check("rst_error", 32'(bus.bus_error), 32'd0);
        check("rst_data", bus.bus_data, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        rd(0, 0);
        check("count_after_reset", bus.bus_data, 32'd0);

        // One-shot on timer 0
        wr(0, 1, 32'd5, 4'hF);
        wr(0, 2, 32'h5, 4'h1);
        idle(5);
        check("oneshot_irq_early", 32'(irq[0]), 32'd0);
        idle(1);
        check("oneshot_irq_rise", 32'(irq[0]), 32'd1);
        rd(0, 2);
        check("oneshot_ctrl", bus.bus_data, 32'h4);
        rd(0, 0);
        check("oneshot_count_hold", bus.bus_data, 32'd0);
        wr(0, 3, 32'h1, 4'h1);
        check("oneshot_irq_clear", 32'(irq[0]), 32'd0);

        // Periodic on timer 1
        wr(1, 1, 32'd3, 4'hF);
        wr(1, 2, 32'h7, 4'h1);
        for (int k = 1; k <= 8; k++) begin
            rd(1, 0);
            check("periodic_count", bus.bus_data, 32'(seq[(k - 1) % 4]));
        end
        wr(1, 3, 32'h1, 4'h1);
        check("status_clear", 32'(irq[1]), 32'd0);
        idle(2);
        wr(1, 3, 32'h1, 4'h1);
        check("expiry_beats_clear", 32'(irq[1]), 32'd1);
        wr(1, 1, 32'h100, 4'h1);
        rd(1, 0);
        check("reload_merge_count", bus.bus_data, 32'd0);
        rd(1, 1);
        check("reload_merge_value", bus.bus_data, 32'd0);
        wr(1, 2, 32'h0, 4'h1);

        // Bad offset and back-to-back reads
        bus_cycle(1'b1, 1'b1, 32'h8000_2020, 32'd0, 1'b0, 4'd0);
        check("bad_offset_error", 32'(bus.bus_error), 32'd1);
        check("bad_offset_ack", 32'(bus.bus_ack), 32'd0);
        check("bad_offset_data", bus.bus_data, 32'd0);
        rd(0, 1);
        check("b2b_reload_ack", 32'(bus.bus_ack), 32'd1);
        check("b2b_reload_data", bus.bus_data, 32'd5);
        rd(0, 2);
        check("b2b_ctrl_ack", 32'(bus.bus_ack), 32'd1);
        check("b2b_ctrl_data", bus.bus_data, 32'h4);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) < 6) begin
                t  = $urandom_range(0, 3);
                r  = $urandom_range(0, 3);
                a  = addr_of(t, r) | 32'($urandom_range(0, 3));
                wv = (r == 1) ? 32'($urandom_range(0, 12)) : $urandom;
                bus_cycle(1'b1, ($urandom_range(0, 7) != 0), a, wv,
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            end else begin
                idle(1);
            end
        end

        // Reset mid-count with an access in flight
        wr(0, 1, 32'd4, 4'hF);
        wr(0, 2, 32'h7, 4'h1);
        idle(8);
        rd(0, 0);
        @(negedge clk);
        bus.bus_access = 1'b1;
        bus.bus_cs     = 1'b1;
        bus.bus_addr   = addr_of(0, 1);
        bus.bus_wr_en  = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check("midrst_ack", 32'(bus.bus_ack), 32'd0);
        check("midrst_error", 32'(bus.bus_error), 32'd0);
        check("midrst_data", bus.bus_data, 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        drive_idle();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        rd(0, 0);
        check("post_rst_count", bus.bus_data, 32'd0);
        check("post_rst_irq", 32'(irq), 32'd0);
        rd(0, 2);
        check("post_rst_ctrl", bus.bus_data, 32'd0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
